ili9341_frame_sequencer: RTL

//  Sequences one full 240x240 frame for the ILI9341 pixel path: reads an 80x80 RGB565 sprite, upscales it 3x, emits pixels.

---
 rtl/ili9341_frame_sequencer_pkg.sv | 63 ++++++
 rtl/ili9341_scale_addr_gen.sv | 79 +++++++
 rtl/ili9341_frame_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ili9341_frame_sequencer_pkg.sv
// Shared definitions for the ILI9341 frame sequencer: scene codes, colours,
// per-scene source table and FSM state encoding.
package ili9341_frame_sequencer_pkg;

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] INICIO  = 4'd1;
   localparam logic [3:0] PAUSA   = 4'd2;
   localparam logic [3:0] COMER   = 4'd3;
   localparam logic [3:0] DORMIR  = 4'd4;
   localparam logic [3:0] JUGAR   = 4'd5;
   localparam logic [3:0] BANAR   = 4'd6;
   localparam logic [3:0] SALUD   = 4'd7;
   localparam logic [3:0] FELIZ   = 4'd8;
   localparam logic [3:0] TRISTE  = 4'd9;
   localparam logic [3:0] HAMBRE  = 4'd10;
   localparam logic [3:0] SUCIO   = 4'd11;
   localparam logic [3:0] CANSADO = 4'd12;
   localparam logic [3:0] MUERTO  = 4'd13;

   localparam logic [15:0] RGB_BLACK  = 16'h0000;
   localparam logic [15:0] RGB_NAVY   = 16'h000F;
   localparam logic [15:0] RGB_RED    = 16'hF800;
   localparam logic [15:0] RGB_GREEN  = 16'h07E0;
   localparam logic [15:0] RGB_BLUE   = 16'h001F;
   localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
   localparam logic [15:0] RGB_GREY   = 16'h8410;
   localparam logic [15:0] RGB_WHITE  = 16'hFFFF;

   typedef enum logic {MODE_SPRITE, MODE_FILL} scene_mode_t;

   // slot selects which SRC_W*SRC_H block of the ROM holds the sprite
   typedef struct packed {
      scene_mode_t mode;
      logic [1:0]  slot;
      logic [15:0] fill;
   } scene_cfg_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_PRESENT, S_DONE
   } seq_state_t;

   function automatic logic [3:0] scene_sanitize(input logic [3:0] code);
      return (code > MUERTO) ? IDLE : code;
   endfunction

   function automatic scene_cfg_t scene_lookup(input logic [3:0] code);
      scene_cfg_t cfg;
      cfg = '{mode: MODE_FILL, slot: 2'd0, fill: RGB_NAVY};
      case (code)
         INICIO, BANAR, TRISTE:           cfg = '{mode: MODE_SPRITE, slot: 2'd0, fill: RGB_BLACK};
         COMER, JUGAR, HAMBRE, CANSADO:   cfg = '{mode: MODE_SPRITE, slot: 2'd1, fill: RGB_BLACK};
         PAUSA:                           cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_RED};
         DORMIR:                          cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_BLUE};
         SALUD:                           cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_GREEN};
         FELIZ:                           cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_YELLOW};
         SUCIO:                           cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_GREY};
         MUERTO:                          cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_WHITE};
         default:                         cfg = '{mode: MODE_FILL,   slot: 2'd0, fill: RGB_NAVY};
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/ili9341_scale_addr_gen.sv
// Source-pixel walker for the upscaler: horizontal/vertical replication counters,
// column/row counters and the ROM row base, producing the sprite word address.
module ili9341_scale_addr_gen #(
   parameter int unsigned SRC_W  = 80,
   parameter int unsigned SRC_H  = 80,
   parameter int unsigned SCALE  = 3,
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              src_pixel_last,
   output logic              frame_last
);

   localparam int unsigned COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
   localparam int unsigned ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
   localparam int unsigned REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [REP_W-1:0]  hrep;
   logic [REP_W-1:0]  vrep;
   logic [ADDR_W-1:0] row_start;
   logic              col_last;
   logic              vrep_last;
   logic              row_last;

   always_comb begin
      col_last       = (col == COL_W'(SRC_W - 1));
      vrep_last      = (vrep == REP_W'(SCALE - 1));
      row_last       = (row == ROW_W'(SRC_H - 1));
      src_pixel_last = (hrep == REP_W'(SCALE - 1));
      frame_last     = src_pixel_last && col_last && vrep_last && row_last;
      mem_addr       = row_start + ADDR_W'(col);
   end

   // The final source pixel of a frame leaves row/row_start in place so the
   // address never steps past the sprite block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col       <= '0;
         row       <= '0;
         hrep      <= '0;
         vrep      <= '0;
         row_start <= '0;
      end else if (load) begin
         col       <= '0;
         row       <= '0;
         hrep      <= '0;
         vrep      <= '0;
         row_start <= base;
      end else if (advance) begin
         if (!src_pixel_last) begin
            hrep <= hrep + 1'b1;
         end else begin
            hrep <= '0;
            if (!col_last) begin
               col <= col + 1'b1;
            end else begin
               col <= '0;
               if (!vrep_last) begin
                  vrep <= vrep + 1'b1;
               end else begin
                  vrep <= '0;
                  if (!row_last) begin
                     row       <= row + 1'b1;
                     row_start <= row_start + ADDR_W'(SRC_W);
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/ili9341_frame_sequencer.sv
// Frame sequencer for the ILI9341 pixel path: walks an upscaled sprite (or a
// solid fill) per frame, with scene changes applied only at frame boundaries.
module ili9341_frame_sequencer
   import ili9341_frame_sequencer_pkg::*;
#(
   parameter int unsigned SRC_W      = 80,
   parameter int unsigned SRC_H      = 80,
   parameter int unsigned SCALE      = 3,
   parameter int unsigned PIXEL_SIZE = 16,
   parameter int unsigned MEM_DEPTH  = 12800,
   localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            scene,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [PIXEL_SIZE-1:0] mem_rd_data,
   output logic [PIXEL_SIZE-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic                  busy
);

   seq_state_t        state;
   seq_state_t        state_nxt;
   scene_cfg_t        cfg;
   logic [3:0]        scene_s;
   logic [3:0]        cur_scene;
   logic [ADDR_W-1:0] base;
   logic              pending;
   logic              started;
   logic              fill_mode;
   logic              accept;
   logic              reload;
   logic              src_pixel_last;
   logic              frame_last;

   assign scene_s = scene_sanitize(scene);
   assign cfg     = scene_lookup(scene_s);
   assign base    = ADDR_W'(32'(cfg.slot) * SRC_W * SRC_H);
   assign accept  = pix_valid && pix_ready;
   assign reload  = pending || (scene_s != cur_scene);

   ili9341_scale_addr_gen #(
      .SRC_W (SRC_W),
      .SRC_H (SRC_H),
      .SCALE (SCALE),
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk           (clk),
      .rst           (rst),
      .load          (state == S_LOAD),
      .advance       (accept),
      .base          (base),
      .mem_addr      (mem_addr),
      .src_pixel_last(src_pixel_last),
      .frame_last    (frame_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    state_nxt = S_LOAD;
         S_LOAD:    state_nxt = (cfg.mode == MODE_FILL) ? S_PRESENT : S_FETCH;
         S_FETCH:   state_nxt = S_WAIT;
         S_WAIT:    state_nxt = S_PRESENT;
         S_PRESENT: begin
            if (accept && src_pixel_last) begin
               if (frame_last)     state_nxt = S_DONE;
               else if (!fill_mode) state_nxt = S_FETCH;
            end
         end
         S_DONE:    if (reload) state_nxt = S_LOAD;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pix_valid   = (state == S_PRESENT);
      mem_rd_en   = (state == S_FETCH);
      frame_start = (state == S_PRESENT) && !started;
      busy        = !((state == S_IDLE) || (state == S_DONE));
   end

   // frame_done drops on the DONE->LOAD edge so it is already low during LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_scene  <= '0;
         pending    <= 1'b0;
         started    <= 1'b0;
         fill_mode  <= 1'b0;
         frame_done <= 1'b0;
         pix_data   <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               cur_scene  <= scene_s;
               fill_mode  <= (cfg.mode == MODE_FILL);
               pending    <= 1'b0;
               started    <= 1'b0;
               frame_done <= 1'b0;
               if (cfg.mode == MODE_FILL) pix_data <= PIXEL_SIZE'(cfg.fill);
            end
            S_WAIT:    pix_data <= mem_rd_data;
            S_PRESENT: begin
               started <= 1'b1;
               if (accept && frame_last) frame_done <= 1'b1;
            end
            S_DONE:    if (reload) frame_done <= 1'b0;
            default:   ;
         endcase
         if ((state == S_FETCH || state == S_WAIT || state == S_PRESENT) && (scene_s != cur_scene))
            pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(frame_done && pix_valid));
         if (state == S_LOAD)
            assert (32'(cfg.slot) * SRC_W * SRC_H + SRC_W * SRC_H <= MEM_DEPTH);
      end
   end

endmodule
